// File: rtl/score_pkg.sv
// Shared types and constants for the tug-of-war scoreboard.
package score_pkg;

  typedef enum logic [1:0] {
    PLAY      = 2'd0,
    ROUND_END = 2'd1,
    DONE      = 2'd2
  } state_e;

  typedef logic [3:0] score_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/blink_timer.sv
// Blink phase generator: phase toggles every BLINK_DIV enabled cycles, starting visible (0).
module blink_timer #(
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic phase
);

  localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);

  logic [CW-1:0] cnt_r;
  logic          phase_r;

  // Half-period counter; held at zero and visible whenever not blinking.
  always_ff @(posedge clk) begin
    if (reset || clear || !enable) begin
      cnt_r   <= '0;
      phase_r <= 1'b0;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r   <= '0;
      phase_r <= ~phase_r;
    end else begin
      cnt_r   <= cnt_r + CW'(1);
      phase_r <= phase_r;
    end
  end

  assign phase = phase_r;

endmodule

// File: rtl/seg7.sv
// Active-low seven-segment decoder for one decimal digit (gfedcba order).
module seg7
  import score_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  // Digit-to-segment lookup; anything outside 0..9 shows blank.
  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/score_ctrl.sv
// Tug-of-war scoreboard: round counting, recentre pulse, match victory and score display.
// Optional winner-digit blink in DONE is compiled in with `define SCORE_BLINK_EN.
module score_ctrl
  import score_pkg::*;
#(
  parameter int WIN_SCORE = 7,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       win_l,
  input  logic       win_r,
  input  logic       new_game,
  output logic       round_clr,
  output logic       game_over,
  output logic       winner,
  output logic [6:0] hex_l,
  output logic [6:0] hex_r
);

  if (WIN_SCORE < 1 || WIN_SCORE > 9) begin : g_bad_win_score
    $error("score_ctrl: WIN_SCORE must be in 1..9");
  end
  if (BLINK_DIV < 1) begin : g_bad_blink_div
    $error("score_ctrl: BLINK_DIV must be at least 1");
  end

  localparam score_t WIN_C = score_t'(WIN_SCORE);

  state_e state_r, state_s;
  score_t score_l_r, score_l_s, score_r_r, score_r_s;
  logic   winner_r, winner_s;
  logic   round_clr_r, round_clr_s;
  logic   game_over_r, game_over_s;
  logic [6:0] dec_l_s, dec_r_s;
  logic   phase_s;

  // State and score registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= PLAY;
      score_l_r   <= 4'd0;
      score_r_r   <= 4'd0;
      winner_r    <= 1'b0;
      round_clr_r <= 1'b0;
      game_over_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      score_l_r   <= score_l_s;
      score_r_r   <= score_r_s;
      winner_r    <= winner_s;
      round_clr_r <= round_clr_s;
      game_over_r <= game_over_s;
    end
  end

  // Next-state logic; new_game overrides everything, simultaneous wins are a tie.
  always_comb begin
    state_s     = state_r;
    score_l_s   = score_l_r;
    score_r_s   = score_r_r;
    winner_s    = winner_r;
    round_clr_s = 1'b0;
    game_over_s = game_over_r;
    if (new_game) begin
      state_s     = PLAY;
      score_l_s   = 4'd0;
      score_r_s   = 4'd0;
      winner_s    = 1'b0;
      game_over_s = 1'b0;
    end else begin
      case (state_r)
        PLAY: begin
          if (win_l ^ win_r) begin
            if (win_l) begin
              score_l_s = score_l_r + 4'd1;
            end else begin
              score_r_s = score_r_r + 4'd1;
            end
            state_s     = ROUND_END;
            round_clr_s = 1'b1;
          end else begin
            state_s = PLAY;
          end
        end
        ROUND_END: begin
          if (score_l_r == WIN_C || score_r_r == WIN_C) begin
            state_s     = DONE;
            game_over_s = 1'b1;
            winner_s    = (score_r_r == WIN_C);
          end else begin
            state_s = PLAY;
          end
        end
        DONE: begin
          state_s     = DONE;
          game_over_s = 1'b1;
        end
        default: begin
          state_s     = PLAY;
          game_over_s = 1'b0;
        end
      endcase
    end
  end

`ifdef SCORE_BLINK_EN
  blink_timer #(
    .BLINK_DIV(BLINK_DIV)
  ) u_blink (
    .clk   (clk),
    .reset (reset),
    .enable(state_r == DONE),
    .clear (new_game),
    .phase (phase_s)
  );
`else
  assign phase_s = 1'b0;
`endif

  seg7 u_seg_l (.digit(score_l_r), .seg(dec_l_s));
  seg7 u_seg_r (.digit(score_r_r), .seg(dec_r_s));

  // Blank only the winner's digit during the hidden blink phase.
  always_comb begin
    hex_l = dec_l_s;
    hex_r = dec_r_s;
    if (phase_s && state_r == DONE) begin
      if (winner_r) begin
        hex_r = SEG_BLANK;
      end else begin
        hex_l = SEG_BLANK;
      end
    end else begin
      hex_l = dec_l_s;
      hex_r = dec_r_s;
    end
  end

  assign round_clr = round_clr_r;
  assign game_over = game_over_r;
  assign winner    = winner_r;

endmodule

// File: tb/tb_score_ctrl.sv
// Scoreboard bench for score_ctrl (WIN_SCORE=3, BLINK_DIV=4); blink checks follow SCORE_BLINK_EN.
module tb_score_ctrl;

  localparam logic [6:0] D0 = 7'b1000000;
  localparam logic [6:0] D1 = 7'b1111001;
  localparam logic [6:0] D2 = 7'b0100100;
  localparam logic [6:0] D3 = 7'b0110000;
  localparam logic [6:0] BL = 7'b1111111;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic win_l = 1'b0, win_r = 1'b0, new_game = 1'b0;
  logic round_clr, game_over, winner;
  logic [6:0] hex_l, hex_r;

  typedef struct {
    int         tgt;
    int         tid;
    logic [6:0] hl;
    logic [6:0] hr;
    logic       rc;
    logic       go;
    logic       w;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int cyc = 0;
  int compared = 0;
  int mismatched = 0;

  score_ctrl #(.WIN_SCORE(3), .BLINK_DIV(4)) dut (
    .clk(clk), .reset(reset), .win_l(win_l), .win_r(win_r), .new_game(new_game),
    .round_clr(round_clr), .game_over(game_over), .winner(winner),
    .hex_l(hex_l), .hex_r(hex_r)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int tid, input logic [6:0] act, input logic [6:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL test%0d %s at cycle %0d: got %b, expected %b", tid, nm, cyc, act, req);
    end
  endtask

  // Monitor: pop the expectation due this cycle and compare every output.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].tgt < cyc) begin
      mismatched++;
      $display("FAIL missed expectation test%0d for cycle %0d: got none, expected a check", sb[0].tid, sb[0].tgt);
      void'(sb.pop_front());
    end
    if (sb.size() > 0 && sb[0].tgt == cyc) begin
      e = sb.pop_front();
      chk("hex_l", e.tid, hex_l, e.hl);
      chk("hex_r", e.tid, hex_r, e.hr);
      chk("round_clr", e.tid, {6'd0, round_clr}, {6'd0, e.rc});
      chk("game_over", e.tid, {6'd0, game_over}, {6'd0, e.go});
      if (e.go) chk("winner", e.tid, {6'd0, winner}, {6'd0, e.w});
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after they are sampled.
  task automatic step(input logic rs, input logic wl, input logic wr, input logic ng,
                      input logic [6:0] ehl, input logic [6:0] ehr,
                      input logic erc, input logic ego, input logic ew, input int tid);
    exp_t x;
    @(posedge clk);
    #1;
    reset = rs; win_l = wl; win_r = wr; new_game = ng;
    x.tgt = cyc + 1; x.tid = tid;
    x.hl = ehl; x.hr = ehr; x.rc = erc; x.go = ego; x.w = ew;
    sb.push_back(x);
  endtask

  function automatic logic [6:0] blink(input int j, input logic [6:0] d);
`ifdef SCORE_BLINK_EN
    return ((j / 4) % 2 == 1) ? BL : d;
`else
    return d;
`endif
  endfunction

  initial begin
    // Test 1: reset then idle
    step(1'b1, 1'b0, 1'b0, 1'b0, D0, D0, 1'b0, 1'b0, 1'b0, 1);
    step(1'b1, 1'b0, 1'b0, 1'b0, D0, D0, 1'b0, 1'b0, 1'b0, 1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b0, D0, D0, 1'b0, 1'b0, 1'b0, 1);

    // Test 2: back-to-back win_l, second is swallowed by ROUND_END
    step(1'b0, 1'b1, 1'b0, 1'b0, D1, D0, 1'b1, 1'b0, 1'b0, 2);
    step(1'b0, 1'b1, 1'b0, 1'b0, D1, D0, 1'b0, 1'b0, 1'b0, 2);
    step(1'b0, 1'b0, 1'b0, 1'b0, D1, D0, 1'b0, 1'b0, 1'b0, 2);

    // Test 3: tie is ignored and FSM stays in PLAY
    step(1'b0, 1'b1, 1'b1, 1'b0, D1, D0, 1'b0, 1'b0, 1'b0, 3);
    step(1'b0, 1'b0, 1'b0, 1'b0, D1, D0, 1'b0, 1'b0, 1'b0, 3);
    step(1'b0, 1'b0, 1'b1, 1'b0, D1, D1, 1'b1, 1'b0, 1'b0, 3);
    step(1'b0, 1'b0, 1'b0, 1'b0, D1, D1, 1'b0, 1'b0, 1'b0, 3);

    // Test 7: reset during ROUND_END drops a concurrent win
    step(1'b0, 1'b1, 1'b0, 1'b0, D2, D1, 1'b1, 1'b0, 1'b0, 7);
    step(1'b1, 1'b0, 1'b1, 1'b0, D0, D0, 1'b0, 1'b0, 1'b0, 7);
    step(1'b0, 1'b0, 1'b0, 1'b0, D0, D0, 1'b0, 1'b0, 1'b0, 7);

    // Test 4/5: right wins 3-0, late win_l ignored, winner digit blinks when enabled
    step(1'b0, 1'b0, 1'b1, 1'b0, D0, D1, 1'b1, 1'b0, 1'b0, 4);
    step(1'b0, 1'b0, 1'b0, 1'b0, D0, D1, 1'b0, 1'b0, 1'b0, 4);
    step(1'b0, 1'b0, 1'b1, 1'b0, D0, D2, 1'b1, 1'b0, 1'b0, 4);
    step(1'b0, 1'b0, 1'b0, 1'b0, D0, D2, 1'b0, 1'b0, 1'b0, 4);
    step(1'b0, 1'b0, 1'b1, 1'b0, D0, D3, 1'b1, 1'b0, 1'b0, 4);
    for (int j = 0; j < 18; j++)
      step(1'b0, (j == 1), 1'b0, 1'b0, D0, blink(j, D3), 1'b0, 1'b1, 1'b1, 5);

    // Test 6: new_game with win_l in DONE restarts cleanly
    step(1'b0, 1'b1, 1'b0, 1'b1, D0, D0, 1'b0, 1'b0, 1'b0, 6);
    step(1'b0, 1'b0, 1'b1, 1'b0, D0, D1, 1'b1, 1'b0, 1'b0, 6);
    step(1'b0, 1'b0, 1'b0, 1'b0, D0, D1, 1'b0, 1'b0, 1'b0, 6);

    // Test 8: left wins, winner = 0, then reset from DONE
    step(1'b0, 1'b0, 1'b0, 1'b1, D0, D0, 1'b0, 1'b0, 1'b0, 8);
    step(1'b0, 1'b1, 1'b0, 1'b0, D1, D0, 1'b1, 1'b0, 1'b0, 8);
    step(1'b0, 1'b0, 1'b0, 1'b0, D1, D0, 1'b0, 1'b0, 1'b0, 8);
    step(1'b0, 1'b1, 1'b0, 1'b0, D2, D0, 1'b1, 1'b0, 1'b0, 8);
    step(1'b0, 1'b0, 1'b0, 1'b0, D2, D0, 1'b0, 1'b0, 1'b0, 8);
    step(1'b0, 1'b1, 1'b0, 1'b0, D3, D0, 1'b1, 1'b0, 1'b0, 8);
    for (int j = 0; j < 6; j++)
      step(1'b0, 1'b0, 1'b0, 1'b0, blink(j, D3), D0, 1'b0, 1'b1, 1'b0, 8);
    step(1'b1, 1'b0, 1'b0, 1'b0, D0, D0, 1'b0, 1'b0, 1'b0, 8);
    step(1'b0, 1'b0, 1'b0, 1'b0, D0, D0, 1'b0, 1'b0, 1'b0, 8);

    for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending expectations, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/score_ctrl.md
# score_ctrl

Scoreboard controller for the tug-of-war game.
- Counts rounds won by each player from single-cycle win pulses produced by the playfield logic.
- Sequences the end-of-round recentre pulse and detects match victory.
- Drives the two score digits on the seven-segment displays through the team's active-low digit decoder, `seg7`, one instance per digit.
- Sits between the playfield/win-detect logic and the HEX outputs at top level.

## Interface
- WIN_SCORE, 7, rounds needed to win the match; legal range 1..9, elaboration error otherwise
- BLINK_DIV, 25_000_000, clock cycles per blink half-period (used only with blink compiled in); minimum 1
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- win_l  in  1  single-cycle pulse: left player won the current round
- win_r  in  1  single-cycle pulse: right player won the current round
- new_game  in  1  single-cycle pulse: clear scores and restart the match
- round_clr  out  1  one-cycle pulse telling the playfield to recentre
- game_over  out  1  high while the match is decided
- winner  out  1  0 = left, 1 = right; meaningful only while game_over = 1
- hex_l  out  7  active-low segments, left score digit
- hex_r  out  7  active-low segments, right score digit

## Operation
- Scores: two 4-bit registers, `score_l` and `score_r`. Range 0..WIN_SCORE; no wrap.
- FSM states: PLAY, ROUND_END, DONE.
- PLAY:
  - Exactly one of win_l / win_r high: increment that score and go to ROUND_END.
  - Both high in the same cycle: treated as a tie. No increment, no state change, no round_clr.
- ROUND_END, lasts exactly one cycle; round_clr = 1.
  - Either score == WIN_SCORE: go to DONE and latch `winner`.
  - Otherwise: return to PLAY.
  - Win pulses arriving in this state are ignored.
- DONE:
  - game_over = 1; `winner` is held.
  - All win pulses are ignored.
  - Stays in DONE until new_game or reset.
- new_game, accepted in any state:
  - Next state PLAY, both scores 0, winner 0, blink counter cleared.
  - Has priority over win_l/win_r in the same cycle; those pulses are dropped.
- Display:
  - hex_l and hex_r are combinational decodes of the registered scores.
  - Digit codes: 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000.
  - Blank = 1111111.
- Reset values: state PLAY, both scores 0, winner 0, round_clr 0, game_over 0, hex_l = hex_r = 1000000, blink counter 0 with phase "visible".
- Reset asserted mid-round or in DONE behaves identically to power-up reset; any win pulse in the same cycle is dropped.

## Timing
- win pulse sampled at edge N:
  - score and corresponding hex digit change after edge N (visible in cycle N+1).
  - round_clr is high for cycle N+1 only.
- Winning pulse:
  - game_over and winner are valid from cycle N+2.
  - round_clr still pulses in cycle N+1.
- Minimum spacing between accepted wins is 2 cycles, because ROUND_END swallows the pulse in cycle N+1.
- new_game at edge N: scores, state and outputs are cleared in cycle N+1.

## Configuration
- `SCORE_BLINK_EN` defined:
  - In DONE, the winner's digit alternates between its decoded score and blank.
  - Each phase lasts BLINK_DIV cycles.
  - The first phase, starting on DONE entry, is visible.
  - The loser's digit stays steady.
  - The blink counter is held at 0 outside DONE.
- `SCORE_BLINK_EN` undefined: no blink counter logic is present, and both digits are steady in all states.

## Structure
- Shared package `score_pkg`:
  - state enum (PLAY, ROUND_END, DONE)
  - `SEG_BLANK` = 7'b1111111
  - 4-bit score typedef
- Sub-module `blink_timer`:
  - Parameterised by BLINK_DIV.
  - Inputs clk, reset, enable, clear; output phase.
  - Instantiated only under `SCORE_BLINK_EN`.
- Two `seg7` decoder instances feed a final blank-mux per digit.

## Test plan
1. Reset, then idle 5 cycles -> hex_l = hex_r = 1000000, game_over = 0, round_clr = 0.
2. win_l pulse at cycle N, second win_l at N+1 -> hex_l = 1111001 from N+1, round_clr high only in N+1, score_l stays 1 (second pulse ignored).
3. win_l and win_r in the same cycle during PLAY -> scores unchanged, round_clr never asserts, state stays PLAY.
4. WIN_SCORE = 3, three spaced win_r pulses, the last at N -> hex_r = 0110000, game_over = 1 and winner = 1 from N+2; a later win_l leaves hex_l = 1000000.
5. `SCORE_BLINK_EN`, BLINK_DIV = 4, right wins with WIN_SCORE = 3 -> hex_r shows 0110000 for 4 cycles, then 1111111 for 4 cycles, repeating; hex_l stays steady.
6. In DONE, new_game together with win_l -> next cycle both hex = 1000000, game_over = 0, state PLAY, score_l = 0.
